// File: rtl/pwm_generate_if.sv
// PWM generator control/status bundle.
// master: configuring agent, slave: pwm_generate.
interface pwm_generate_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] high_count;
  logic [WIDTH-1:0] low_count;
  logic             load;
  logic             enable;
  logic             signal;
  logic             period_done;
  logic             cfg_pending;

  modport master (
    output high_count,
    output low_count,
    output load,
    output enable,
    input  signal,
    input  period_done,
    input  cfg_pending
  );

  modport slave (
    input  high_count,
    input  low_count,
    input  load,
    input  enable,
    output signal,
    output period_done,
    output cfg_pending
  );
endinterface

// File: rtl/pwm_generate.sv
// PWM transmitter: high for act_h cycles, low for act_l cycles.
// Settings are double-buffered and applied only at period boundaries.
module pwm_generate #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  pwm_generate_if.slave pwm
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_h_q, act_h_d;
  logic [WIDTH-1:0] act_l_q, act_l_d;
  logic [WIDTH-1:0] pend_h_q, pend_h_d;
  logic [WIDTH-1:0] pend_l_q, pend_l_d;
  logic             pend_q, pend_d;
  logic             sig_q;
  logic             done_q, done_d;

  logic             h_end;
  logic             l_end;
  logic             eval;
  logic [WIDTH-1:0] nxt_h;
  logic [WIDTH-1:0] nxt_l;

  always_comb begin
    h_end = (state_q == HIGH) && (cnt_q == act_h_q);
    l_end = (state_q == LOW) && (cnt_q == act_l_q);
    eval  = ((state_q == IDLE) && pwm.enable)
          || (h_end && (act_l_q == '0))
          || l_end;
    nxt_h = pend_q ? pend_h_q : act_h_q;
    nxt_l = pend_q ? pend_l_q : act_l_q;

    state_d  = state_q;
    cnt_d    = (state_q == IDLE) ? cnt_q : cnt_q + WIDTH'(1);
    act_h_d  = act_h_q;
    act_l_d  = act_l_q;
    pend_h_d = pend_h_q;
    pend_l_d = pend_l_q;
    pend_d   = pend_q;
    done_d   = 1'b0;

    unique case (1'b1)
      eval: begin
        act_h_d = nxt_h;
        act_l_d = nxt_l;
        pend_d  = 1'b0;
        cnt_d   = WIDTH'(1);
        if ((state_q != IDLE) && !pwm.enable) begin
          state_d = IDLE;
        end else if (nxt_h != '0) begin
          state_d = HIGH;
          done_d  = 1'b1;
        end else if (nxt_l != '0) begin
          state_d = LOW;
          done_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      h_end && (act_l_q != '0): begin
        state_d = LOW;
        cnt_d   = WIDTH'(1);
      end
      default: ;
    endcase

    // A load on a boundary cycle lands after the boundary consumed pend
    if (pwm.load) begin
      pend_h_d = pwm.high_count;
      pend_l_d = pwm.low_count;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      act_h_q  <= '0;
      act_l_q  <= '0;
      pend_h_q <= '0;
      pend_l_q <= '0;
      pend_q   <= 1'b0;
      sig_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      act_h_q  <= act_h_d;
      act_l_q  <= act_l_d;
      pend_h_q <= pend_h_d;
      pend_l_q <= pend_l_d;
      pend_q   <= pend_d;
      sig_q    <= (state_d == HIGH);
      done_q   <= done_d;
    end
  end

  assign pwm.signal      = sig_q;
  assign pwm.period_done = done_q;
  assign pwm.cfg_pending = pend_q;

endmodule

// File: tb/tb_pwm_generate.sv
// Directed bench for pwm_generate.
// Expected waveforms are hand-derived bit patterns, MSB = first cycle.
module tb_pwm_generate;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pwm_generate_if #(.WIDTH(32)) pwm_if ();

  pwm_generate #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .pwm   (pwm_if)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic ld(input logic [31:0] h, input logic [31:0] l);
    pwm_if.high_count = h;
    pwm_if.low_count  = l;
    pwm_if.load       = 1'b1;
    tick();
    pwm_if.load       = 1'b0;
  endtask

  task automatic run_chk(input string tag,
                         input int n,
                         input logic [31:0] s,
                         input logic [31:0] d,
                         input logic [31:0] p);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.sig[%0d]", tag, i), 32'(pwm_if.signal), 32'(s[n-1-i]));
      chk($sformatf("%s.done[%0d]", tag, i), 32'(pwm_if.period_done), 32'(d[n-1-i]));
      chk($sformatf("%s.pend[%0d]", tag, i), 32'(pwm_if.cfg_pending), 32'(p[n-1-i]));
      tick();
    end
  endtask

  initial begin
    int n;
    int m;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    pwm_if.high_count = '0;
    pwm_if.low_count  = '0;
    pwm_if.load       = 1'b0;
    pwm_if.enable     = 1'b0;
    tick();
    tick();
    chk("rst.sig", 32'(pwm_if.signal), 0);
    chk("rst.done", 32'(pwm_if.period_done), 0);
    chk("rst.pend", 32'(pwm_if.cfg_pending), 0);
    reset = 1'b0;

    // 3/2 from START
    ld(3, 2);
    chk("ld.pend", 32'(pwm_if.cfg_pending), 1);
    chk("ld.sig", 32'(pwm_if.signal), 0);
    pwm_if.enable = 1'b1;
    tick();
    run_chk("p32", 10, 32'b1110011100, 32'b1000010000, 32'b0);

    // reload during HIGH: current period finishes first
    ld(1, 4);
    run_chk("p14", 10, 32'b1100100001, 32'b0000100001, 32'b1111000000);

    // low_count = 0: constant high
    ld(4, 0);
    run_chk("p40", 12, 32'b000111111111, 32'b000100010001, 32'b111000000000);

    // high_count = 0: constant low
    ld(0, 5);
    run_chk("p05", 13, 32'b1100000000000, 32'b0010000100001,
            32'b1100000000000);

    // both zero: park in IDLE
    ld(0, 0);
    run_chk("p00", 8, 32'b0, 32'b0, 32'b11100000);

    // restart from IDLE with enable held high
    ld(3, 2);
    run_chk("rst32", 7, 32'b0111001, 32'b0100001, 32'b1000000);

    // drop enable on the 2nd high cycle
    pwm_if.enable = 1'b0;
    run_chk("dis", 6, 32'b110000, 32'b0, 32'b0);
    pwm_if.enable = 1'b1;
    run_chk("reen", 2, 32'b01, 32'b01, 32'b0);

    // reset mid-HIGH with a pending load
    ld(7, 7);
    chk("mid.pend", 32'(pwm_if.cfg_pending), 1);
    chk("mid.sig", 32'(pwm_if.signal), 1);
    reset = 1'b1;
    tick();
    chk("mrst.sig", 32'(pwm_if.signal), 0);
    chk("mrst.done", 32'(pwm_if.period_done), 0);
    chk("mrst.pend", 32'(pwm_if.cfg_pending), 0);
    reset = 1'b0;
    tick();
    chk("post.sig", 32'(pwm_if.signal), 0);
    chk("post.done", 32'(pwm_if.period_done), 0);

    // load exactly on a boundary cycle
    ld(3, 2);
    tick();
    tick();
    ld(2, 1);
    tick();
    tick();
    chk("bnd.pend", 32'(pwm_if.cfg_pending), 1);
    chk("bnd.sig", 32'(pwm_if.signal), 0);
    ld(1, 1);
    run_chk("bnd", 6, 32'b110101, 32'b100101, 32'b111000);

    // long 40000/10000 period, measured by run length
    ld(40000, 10000);
    n = 0;
    while (!(pwm_if.period_done && !pwm_if.cfg_pending) && n < 100) begin
      tick();
      n++;
    end
    chk("long.start", 32'(n < 100), 1);
    n = 0;
    while (pwm_if.signal && n < 50000) begin
      tick();
      n++;
    end
    chk("long.high", 32'(n), 40000);
    m = 0;
    while (!pwm_if.signal && m < 20000) begin
      tick();
      m++;
    end
    chk("long.low", 32'(m), 10000);
    chk("long.done", 32'(pwm_if.period_done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
